// File: rtl/dsp_mac_sequencer_if.sv
// Operand-pair stream in and dot-product result out for dsp_mac_sequencer.
interface dsp_mac_sequencer_if #(
  parameter int CNT_W = 16
);
  logic               s_valid;
  logic               s_ready;
  logic signed [17:0] s_a;
  logic signed [17:0] s_b;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic signed [47:0] m_result;
  logic [CNT_W-1:0]   m_count;

  modport slave (
    input  s_valid, s_a, s_b, s_last, m_ready,
    output s_ready, m_valid, m_result, m_count
  );

  modport master (
    output s_valid, s_a, s_b, s_last, m_ready,
    input  s_ready, m_valid, m_result, m_count
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP48A1 slice so its post-adder accumulates each vector's dot product,
// and captures P when the vector's last product has reached the accumulator.
module dsp_mac_sequencer #(
  parameter int DSP_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  dsp_mac_sequencer_if.slave        bus,
  output logic signed [17:0]        dsp_a,
  output logic signed [17:0]        dsp_b,
  output logic        [7:0]         dsp_opmode,
  output logic                      dsp_ce,
  output logic                      dsp_rst,
  input  logic signed [47:0]        dsp_p
);
  localparam int STAGES = DSP_LAT + 1;
  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;

  // First pair of a vector restarts the accumulator; everything else (bubbles too) adds M.
  function automatic logic [7:0] opmode_code(input logic acc, input logic first);
    return (acc && first) ? OPM_LOAD : OPM_ACC;
  endfunction

  logic               rdy_q;
  logic               first_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [7:0]         code_p0;
  logic               tag_last_p [STAGES];
  logic [CNT_W-1:0]   tag_cnt_p  [STAGES];
  logic               m_valid_q;
  logic signed [47:0] m_result_q;
  logic [CNT_W-1:0]   m_count_q;
  logic               stall;
  logic               s_rdy;
  logic               accept;
  logic               capture;

  assign stall   = tag_last_p[STAGES-1] && m_valid_q && !bus.m_ready;
  assign s_rdy   = rdy_q && !rst && !stall;
  assign accept  = bus.s_valid && s_rdy;
  assign capture = tag_last_p[STAGES-1] && (!m_valid_q || bus.m_ready);
  assign cnt_nxt = cnt_q + CNT_W'(1);

  assign bus.s_ready  = s_rdy;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_result = m_result_q;
  assign bus.m_count  = m_count_q;
  // Freezing the whole slice keeps the pending sum in P until the result slot frees up.
  assign dsp_ce       = rst || !stall;
  assign dsp_rst      = rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      first_q    <= 1'b1;
      cnt_q      <= '0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      code_p0    <= '0;
      dsp_opmode <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_last_p[i] <= 1'b0;
        tag_cnt_p[i]  <= '0;
      end
      m_valid_q  <= 1'b0;
      m_result_q <= '0;
      m_count_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (!stall) begin
        // Stage p0: issue to slice A0/B0, tag enters pipeline
        dsp_a         <= accept ? bus.s_a : '0;
        dsp_b         <= accept ? bus.s_b : '0;
        code_p0       <= opmode_code(accept, first_q);
        tag_last_p[0] <= accept && bus.s_last;
        tag_cnt_p[0]  <= accept ? cnt_nxt : '0;
        // Stage p1: opmode lines up with the slice M register
        dsp_opmode    <= code_p0;
        for (int i = 1; i < STAGES; i++) begin
          tag_last_p[i] <= tag_last_p[i-1];
          tag_cnt_p[i]  <= tag_cnt_p[i-1];
        end
      end
      if (accept) begin
        first_q <= bus.s_last;
        cnt_q   <= bus.s_last ? '0 : cnt_nxt;
      end
      // Output stage: P holds the full vector sum when the last tag arrives
      if (capture) begin
        m_result_q <= dsp_p;
        m_count_q  <= tag_cnt_p[STAGES-1];
        m_valid_q  <= 1'b1;
      end else if (bus.m_ready) begin
        m_valid_q  <= 1'b0;
      end
    end
  end
endmodule
